// File: rtl/writeback_arbiter_if.sv
// Bundle of the three functional-unit result channels and the register-file write side.
// The FU side drives valid/addr/data; the arbiter returns ready and the write/retire outputs.
interface writeback_arbiter_if #(
   parameter int CNT_W = 16
);
   logic              alu_valid;
   logic              alu_ready;
   logic [4:0]        alu_addr;
   logic [31:0]       alu_data;
   logic              mul_valid;
   logic              mul_ready;
   logic [4:0]        mul_addr;
   logic [31:0]       mul_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [4:0]        mem_addr;
   logic [31:0]       mem_data;
   logic              enc;
   logic [4:0]        addrc;
   logic [31:0]       datac;
   logic              done_valid;
   logic [4:0]        done_addr;
   logic [2:0]        pending;
   logic [CNT_W-1:0]  wb_count;

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mul_valid, mul_addr, mul_data,
      output mem_valid, mem_addr, mem_data,
      input  alu_ready, mul_ready, mem_ready,
      input  enc, addrc, datac, done_valid, done_addr, pending, wb_count
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mul_valid, mul_addr, mul_data,
      input  mem_valid, mem_addr, mem_data,
      output alu_ready, mul_ready, mem_ready,
      output enc, addrc, datac, done_valid, done_addr, pending, wb_count
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: three per-unit result FIFOs, round-robin retire of one
// result per cycle into the write port, plus a completion pulse for the issue scoreboard.
module writeback_arbiter #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   writeback_arbiter_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [36:0] entry_t;

   logic [2:0]   valid_in;
   logic [4:0]   addr_in  [3];
   logic [31:0]  data_in  [3];

   entry_t       store    [3][DEPTH];
   logic [PW-1:0] rd_ptr  [3];
   logic [PW-1:0] wr_ptr  [3];
   logic [PW:0]  cnt      [3];
   logic [PW:0]  cnt_next [3];

   logic [2:0]   ready;
   logic [2:0]   push;
   logic [2:0]   pop;
   logic [2:0]   nonempty;
   logic [1:0]   rr;
   logic [1:0]   gidx;
   logic         grant;
   entry_t       head;

   logic             enc_p1;
   logic [4:0]       addrc_p1;
   logic [31:0]      datac_p1;
   logic             done_valid_p1;
   logic [4:0]       done_addr_p1;
   logic [2:0]       pending_p1;
   logic [CNT_W-1:0] count_p1;

   assign valid_in   = {bus.mem_valid, bus.mul_valid, bus.alu_valid};
   assign addr_in[0] = bus.alu_addr;
   assign addr_in[1] = bus.mul_addr;
   assign addr_in[2] = bus.mem_addr;
   assign data_in[0] = bus.alu_data;
   assign data_in[1] = bus.mul_data;
   assign data_in[2] = bus.mem_data;

   assign bus.alu_ready  = ready[0];
   assign bus.mul_ready  = ready[1];
   assign bus.mem_ready  = ready[2];
   assign bus.enc        = enc_p1;
   assign bus.addrc      = addrc_p1;
   assign bus.datac      = datac_p1;
   assign bus.done_valid = done_valid_p1;
   assign bus.done_addr  = done_addr_p1;
   assign bus.pending    = pending_p1;
   assign bus.wb_count   = count_p1;

   // Ready is decoded from the registered count only, so a full FIFO never passes through.
   always_comb begin
      ready    = '0;
      push     = '0;
      nonempty = '0;
      for (int i = 0; i < 3; i++) begin
         ready[i]    = ~reset & (cnt[i] < (PW+1)'(DEPTH));
         push[i]     = valid_in[i] & ready[i];
         nonempty[i] = (cnt[i] != '0);
      end
   end

   // Round-robin search starting at rr; first non-empty FIFO wins.
   always_comb begin
      int j;
      j     = 0;
      grant = 1'b0;
      gidx  = 2'd0;
      pop   = '0;
      for (int k = 0; k < 3; k++) begin
         j = int'(rr) + k;
         if (j >= 3) j = j - 3;
         if (!grant && nonempty[j]) begin
            grant = 1'b1;
            gidx  = 2'(j);
         end
      end
      if (grant) pop[gidx] = 1'b1;
      head = store[gidx][rd_ptr[gidx]];
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_next[i] = cnt[i];
         case ({push[i], pop[i]})
            2'b10:   cnt_next[i] = cnt[i] + (PW+1)'(1);
            2'b01:   cnt_next[i] = cnt[i] - (PW+1)'(1);
            default: cnt_next[i] = cnt[i];
         endcase
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (push[i]) store[i][wr_ptr[i]] <= {addr_in[i], data_in[i]};
      end
   end

   // Stage p1: FIFO bookkeeping and the registered write-port outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
         rr            <= 2'd0;
         enc_p1        <= 1'b0;
         addrc_p1      <= '0;
         datac_p1      <= '0;
         done_valid_p1 <= 1'b0;
         done_addr_p1  <= '0;
         pending_p1    <= '0;
         count_p1      <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            cnt[i]        <= cnt_next[i];
            pending_p1[i] <= (cnt_next[i] != '0);
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
         end
         if (grant) begin
            rr            <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
            enc_p1        <= (head[36:32] != 5'd0);
            addrc_p1      <= head[36:32];
            datac_p1      <= head[31:0];
            done_valid_p1 <= 1'b1;
            done_addr_p1  <= head[36:32];
            count_p1      <= count_p1 + CNT_W'(1);
         end else begin
            enc_p1        <= 1'b0;
            done_valid_p1 <= 1'b0;
         end
      end
   end
endmodule
